// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream in / instruction-memory write out bundle.
//   master : stream producer and memory-side observer (drives start, word_count,
//            byte_in, byte_valid; sees byte_ready and the write/status outputs)
//   slave  : the loader itself
interface imem_loader_if;
  logic        start;
  logic [7:0]  word_count;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        cpu_hold;

  modport master (
    output start, word_count, byte_in, byte_valid,
    input  byte_ready, wr_en, wr_addr, wr_data, busy, done, cpu_hold
  );

  modport slave (
    input  start, word_count, byte_in, byte_valid,
    output byte_ready, wr_en, wr_addr, wr_data, busy, done, cpu_hold
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: packs a big-endian byte stream into 32-bit instruction words and
// writes them to instruction memory at incrementing (wrapping) word addresses,
// holding the core stalled while a load is in progress.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : start/word_count control, byte_in/byte_valid/byte_ready stream,
//                wr_en/wr_addr/wr_data memory write, busy/done/cpu_hold status
// All outputs are registers; they are loaded from the next-state decode so they
// line up with the state they describe.
module imem_loader #(
  parameter int ADDR_BITS  = 7,
  parameter int START_ADDR = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  imem_loader_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_e;

  // Counter wide enough to hold 2^ADDR_BITS and any 8-bit word_count.
  localparam int CW = (ADDR_BITS + 2 > 9) ? ADDR_BITS + 2 : 9;
  localparam logic [CW-1:0] MAX_WORDS = CW'(1) << ADDR_BITS;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [CW-1:0]          word_q, word_d;
  logic [1:0]             byte_q, byte_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [31:0]            data_q, data_d;
  logic                   ready_q, ready_d;
  logic                   wr_en_q, wr_en_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [CW-1:0]          wc_ext;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    byte_d  = byte_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wc_ext  = CW'(bus.word_count);

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          cnt_d   = (wc_ext > MAX_WORDS) ? MAX_WORDS : wc_ext;
          addr_d  = ADDR_BITS'(START_ADDR);
          byte_d  = 2'd0;
          word_d  = '0;
          state_d = (wc_ext == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (bus.byte_valid && ready_q) begin
          case (byte_q)
            2'd0:    data_d[31:24] = bus.byte_in;
            2'd1:    data_d[23:16] = bus.byte_in;
            2'd2:    data_d[15:8]  = bus.byte_in;
            default: data_d[7:0]   = bus.byte_in;
          endcase
          byte_d = byte_q + 2'd1;  // wraps to 0 after the last byte
          if (byte_q == 2'd3) state_d = WRITE;
        end
      end
      WRITE: begin
        // Address rolls over naturally at ADDR_BITS.
        word_d  = word_q + CW'(1);
        addr_d  = addr_q + ADDR_BITS'(1);
        state_d = (word_q + CW'(1) == cnt_q) ? DONE : LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_d = (state_d == LOAD);
    wr_en_d = (state_d == WRITE);
    busy_d  = (state_d == LOAD) || (state_d == WRITE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      byte_q  <= 2'd0;
      addr_q  <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      wr_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      byte_q  <= byte_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      wr_en_q <= wr_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.byte_ready = ready_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = {{(32-ADDR_BITS){1'b0}}, addr_q};
  assign bus.wr_data    = data_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.cpu_hold   = busy_q;

endmodule

// File: doc/imem_loader.md
# imem_loader

Write-side companion to the instruction memory. It accepts a byte stream over a valid/ready handshake and packs each group of four bytes big-endian into a 32-bit instruction word. It then issues one-cycle write strobes to the instruction memory at incrementing word addresses. While loading, it holds the core in stall via `cpu_hold`, so fetch never reads a partially loaded program.

## Interface
Parameters:
- `ADDR_BITS`, default 7: word-index width. Memory depth is 2^ADDR_BITS = 128 words.
- `START_ADDR`, default 0: word index of the first write.

Ports:
- Clock and reset: one clock, `clk`. Reset is synchronous and active-low, `rst_n`, sampled on the rising edge of `clk`.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous active-low reset.
- `start` in 1: begin a load; honoured only in IDLE or DONE.
- `word_count` in 8: number of words to load, sampled with `start`.
  - 0 completes immediately with no writes.
  - Values above 2^ADDR_BITS are clamped to 2^ADDR_BITS.
- `byte_in` in 8: stream data.
- `byte_valid` in 1: `byte_in` is valid.
- `byte_ready` out 1: loader accepts a byte this cycle.
- `wr_en` out 1: write strobe to instruction memory, one cycle per word.
- `wr_addr` out 32: word index, same indexing as the fetch-side `addr`.
  - Bits [ADDR_BITS-1:0] carry the index; all upper bits are 0.
- `wr_data` out 32: assembled instruction word.
- `busy` out 1: high in LOAD and WRITE.
- `done` out 1: high in DONE.
- `cpu_hold` out 1: equals `busy`; drives the core stall.

## Operation
- States are IDLE, LOAD, WRITE and DONE.
- Reset values: state IDLE; `byte_ready`, `wr_en`, `busy`, `done` and `cpu_hold` all 0; `wr_addr` 0; `wr_data` 0; byte counter 0; word counter 0.
- IDLE or DONE, on `start`:
  - Latch the clamped `word_count`.
  - Set the address to START_ADDR and clear both counters.
  - Next state is DONE if the count is 0, otherwise LOAD. `done` clears on entry to LOAD.
- LOAD:
  - `byte_ready` is 1.
  - A byte is accepted on each edge where `byte_valid && byte_ready`.
  - Bytes 0, 1, 2 and 3 fill `wr_data` bits [31:24], [23:16], [15:8] and [7:0] respectively.
  - Accepting byte 3 moves the state to WRITE.
- WRITE, one cycle:
  - `wr_en` is 1 and `byte_ready` is 0.
  - `wr_addr` and `wr_data` are stable for the whole cycle.
  - On the exit edge: increment the word counter and the address. The address wraps modulo 2^ADDR_BITS.
  - Next state is DONE if the word counter has reached the latched count, otherwise LOAD.
- DONE: `done` stays 1 until the next `start` or reset. `wr_addr` and `wr_data` hold their last values.
- `start` in LOAD or WRITE is ignored.
- Bytes offered in IDLE, WRITE or DONE are not accepted (`byte_ready` is 0).
- Reset during LOAD or WRITE:
  - Go to IDLE next edge and discard the partial word.
  - No `wr_en` is issued after the reset edge.
  - Memory contents already written are untouched.
- Starting from START_ADDR ≠ 0 with a count of 128 wraps the address through 127 to 0, ending at START_ADDR-1. No error is flagged.

## Timing
- All outputs are registered; none depends combinationally on inputs.
- Minimum rate is 5 cycles per word: 4 accepted bytes, then 1 WRITE cycle.
- `byte_valid` gaps stall LOAD indefinitely. No timeout.
- The `start` edge puts the state in LOAD, so `byte_ready` is 1 on the next cycle.
- The edge accepting byte 3 puts the state in WRITE, so `wr_en` is 1 in the next cycle.
- For the final word, `done` and `cpu_hold`=0 are asserted in the cycle after the `wr_en` cycle.
- The write lands in memory on the edge closing the `wr_en` cycle. Fetch may read it once `cpu_hold` falls.

## Test plan
- Basic load:
  - Stimulus: reset, then `start` with count=2, then bytes 00 23 00 AA 10 25 43 21 with continuous valid.
  - Required: `wr_en` at addr 0 with data 0x002300AA, then at addr 1 with data 0x10254321, in cycles 5 and 10 after the first accepted byte.
  - Then `done`=1 and `cpu_hold`=0.
- Throttled stream:
  - Stimulus: `byte_valid` toggled 1/0 every cycle, bytes 8C 12 34 56.
  - Required: exactly one `wr_en`, data 0x8C123456, `byte_ready` 0 during the WRITE cycle.
- Zero count:
  - Stimulus: `start` with count=0.
  - Required: DONE the next cycle, no `wr_en`, `busy` never 1.
- Wrap and clamp:
  - Stimulus: START_ADDR=126, count=200.
  - Required: 128 writes, addresses 126, 127, 0, … 125.
  - Upper 25 bits of `wr_addr` are always 0.
- Reset mid-word:
  - Stimulus: assert `rst_n`=0 after 2 bytes of word 1, then `start` again with 4 new bytes.
  - Required: no write of the partial word; the new word is written at START_ADDR.
- Restart from DONE:
  - Stimulus: after load A completes, `start` with count=1. Also pulse `start` mid-LOAD.
  - Required: the mid-LOAD `start` is ignored. `done` falls on entry to LOAD, and the second load writes at START_ADDR.
